barrier_sync_controller: RTL and testbench

// Handshaked arrival/release sequencer for a multi-level synchronisation barrier.

---
 rtl/barrier_sync_controller.sv | 142 ++++++++++++++
 tb/tb_barrier_sync_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/barrier_sync_controller.sv
// barrier_sync_controller
// Arrival/release sequencer for a multi-level synchronisation barrier.
// Each level posts arrivals with a valid/ready handshake. The block keeps an
// outstanding-arrival count per level. It fires a one-cycle release pulse to
// every enabled level once all enabled levels have at least one arrival pending.
//
// Optional feature: define BARRIER_WATCHDOG_EN to add a GATHER-state watchdog.
// The watchdog sets a sticky timeout flag after TIMEOUT_CYCLES consecutive
// GATHER cycles. When the macro is undefined, timeout is tied to 0.
module barrier_sync_controller #(
  parameter int NUM_LEVELS     = 4,
  parameter int COUNT_BITS     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_LEVELS-1:0]            level_enable,
  input  logic [NUM_LEVELS-1:0]            arrive_valid,
  output logic [NUM_LEVELS-1:0]            arrive_ready,
  output logic [NUM_LEVELS-1:0]            resume,
  output logic [NUM_LEVELS*COUNT_BITS-1:0] pending,
  output logic [7:0]                       release_count,
  output logic                             busy,
  output logic                             timeout
);

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATHER  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [COUNT_BITS-1:0] count_q [NUM_LEVELS];
  logic [COUNT_BITS-1:0] count_d [NUM_LEVELS];
  logic [7:0]            release_count_q;

  logic [NUM_LEVELS-1:0] accept;     // handshake completed this cycle
  logic [NUM_LEVELS-1:0] decr;       // level consumes one arrival this cycle
  logic [NUM_LEVELS-1:0] nonzero_d;  // post-update count is nonzero
  logic [NUM_LEVELS-1:0] level_ok_d; // level does not block the release
  logic                  in_release;
  logic                  release_cond;

  assign in_release = (state_q == RELEASE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEVELS; gi++) begin : g_level
      // Ready is taken from the registered count, before any decrement.
      // A full level therefore waits one cycle during a release instead of
      // being accepted and decremented in the same cycle.
      assign arrive_ready[gi] = level_enable[gi] && (count_q[gi] != CNT_MAX);
      assign accept[gi]       = arrive_valid[gi] && arrive_ready[gi];

      // The count guard prevents underflow if a level is enabled while the
      // barrier is already releasing.
      assign decr[gi] = in_release && level_enable[gi] && (count_q[gi] != '0);

      // Post-update count. Ready is low at full, so the sum cannot overflow.
      always_comb begin
        count_d[gi] = count_q[gi] + COUNT_BITS'(accept[gi]) - COUNT_BITS'(decr[gi]);
      end

      assign nonzero_d[gi]  = (count_d[gi] != '0);
      assign level_ok_d[gi] = !level_enable[gi] || nonzero_d[gi];

      assign pending[gi*COUNT_BITS +: COUNT_BITS] = count_q[gi];
      // Follows the live enable, so a level dropped mid-release is not pulsed.
      assign resume[gi] = in_release && level_enable[gi];

      // Per-level outstanding-arrival counter.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_q[gi] <= '0;
        end else begin
          count_q[gi] <= count_d[gi];
        end
      end
    end
  endgenerate

  // Release requires at least one enabled level, all holding an arrival.
  assign release_cond = (|level_enable) && (&level_ok_d);

  // Next state from the post-update counts.
  always_comb begin
    state_d = IDLE;
    if (release_cond) begin
      state_d = RELEASE;
    end else if (|nonzero_d) begin
      state_d = GATHER;
    end
  end

  // Barrier state and release counter (wraps 255 -> 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      release_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_release) begin
        release_count_q <= release_count_q + 8'd1;
      end
    end
  end

  assign release_count = release_count_q;
  assign busy          = (state_q != IDLE);

`ifdef BARRIER_WATCHDOG_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_BITS-1:0] wd_q;
  logic               timeout_q;

  // Counts consecutive GATHER cycles. The flag stays set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == GATHER) begin
      if (wd_q == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
        timeout_q <= 1'b1;
      end
      if (wd_q != WD_BITS'(TIMEOUT_CYCLES)) begin
        wd_q <= wd_q + 1'b1;
      end
    end else begin
      wd_q <= '0;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_barrier_sync_controller.sv
// Testbench for barrier_sync_controller.
// The bench runs directed scenarios and then randomized traffic. Each cycle it
// compares the DUT outputs with a reference model. The model keeps integer
// counts plus a "releasing" flag.
module tb_barrier_sync_controller;

  localparam int N   = 4;
  localparam int CB  = 4;
  localparam int TMO = 16;
  localparam int CMAX = (1 << CB) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    level_enable;
  logic [N-1:0]    arrive_valid;
  logic [N-1:0]    arrive_ready;
  logic [N-1:0]    resume;
  logic [N*CB-1:0] pending;
  logic [7:0]      release_count;
  logic            busy;
  logic            timeout;

  barrier_sync_controller #(
    .NUM_LEVELS    (N),
    .COUNT_BITS    (CB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .level_enable (level_enable),
    .arrive_valid (arrive_valid),
    .arrive_ready (arrive_ready),
    .resume       (resume),
    .pending      (pending),
    .release_count(release_count),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_cnt [N];
  bit m_rel;
  int m_rc;
  int m_run;
  bit m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_rel = 0;
    m_rc  = 0;
    m_run = 0;
    m_to  = 0;
  endtask

  // One clock cycle. Apply the inputs, check the outputs at the negedge, then
  // advance the model at the posedge.
  task automatic run_cycle(input logic rst, input logic [N-1:0] en, input logic [N-1:0] vld);
    logic [N-1:0]    e_ready;
    logic [N-1:0]    e_resume;
    logic [N*CB-1:0] e_pend;
    bit              any_nz;
    bit              gather;
    int              old;
    reset        = rst;
    level_enable = en;
    arrive_valid = vld;
    e_ready  = '0;
    e_resume = '0;
    e_pend   = '0;
    any_nz   = 0;
    for (int i = 0; i < N; i++) begin
      e_ready[i]  = en[i] && (m_cnt[i] < CMAX);
      e_resume[i] = m_rel && en[i];
      e_pend[i*CB +: CB] = m_cnt[i][CB-1:0];
      if (m_cnt[i] != 0) any_nz = 1;
    end
    @(negedge clk);
    check_eq("ready",   32'(arrive_ready),  32'(e_ready));
    check_eq("resume",  32'(resume),        32'(e_resume));
    check_eq("pending", 32'(pending),       32'(e_pend));
    check_eq("rel_cnt", 32'(release_count), 32'(m_rc));
    check_eq("busy",    32'(busy),          32'(m_rel || any_nz));
    check_eq("timeout", 32'(timeout),       32'(m_to));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      gather = !m_rel && any_nz;
`ifdef BARRIER_WATCHDOG_EN
      if (gather) begin
        m_run++;
        if (m_run >= TMO) m_to = 1;
      end else begin
        m_run = 0;
      end
`else
      m_run = gather ? m_run + 1 : 0;
`endif
      for (int i = 0; i < N; i++) begin
        old = m_cnt[i];
        m_cnt[i] = old + ((e_ready[i] && vld[i]) ? 1 : 0)
                       - ((m_rel && en[i] && old > 0) ? 1 : 0);
      end
      if (m_rel) m_rc = (m_rc + 1) % 256;
      m_rel = (en != '0);
      for (int i = 0; i < N; i++) begin
        if (en[i] && m_cnt[i] == 0) m_rel = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    run_cycle(1'b1, 4'hF, 4'h0);
    run_cycle(1'b1, 4'hF, 4'h0);
  endtask

  initial begin
    logic [N-1:0] en;
    logic [7:0]   rc_snap;
    reset        = 1'b1;
    level_enable = '1;
    arrive_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state.
    run_cycle(1'b0, 4'hF, 4'h0);
    check_eq("rst_ready", 32'(arrive_ready), 32'hF);
    check_eq("rst_busy",  32'(busy), 32'h0);

    // Sequential arrivals L0..L3, then one release.
    for (int l = 0; l < N; l++) run_cycle(1'b0, 4'hF, 4'(1 << l));
    check_eq("seq_resume", 32'(resume), 32'hF);
    run_cycle(1'b0, 4'hF, 4'h0);
    check_eq("seq_rc",     32'(release_count), 32'd1);
    check_eq("seq_busy",   32'(busy), 32'd0);
    run_cycle(1'b0, 4'hF, 4'h0);

    // Fill L0 to full, then complete the barrier.
    do_reset();
    for (int k = 0; k < 16; k++) run_cycle(1'b0, 4'hF, 4'h1);
    check_eq("full_ready0", 32'(arrive_ready[0]), 32'd0);
    check_eq("full_cnt0",   32'(pending[CB-1:0]), 32'd15);
    run_cycle(1'b0, 4'hF, 4'hE);
    run_cycle(1'b0, 4'hF, 4'h0);
    check_eq("full_after_cnt0",   32'(pending[CB-1:0]), 32'd14);
    check_eq("full_after_ready0", 32'(arrive_ready[0]), 32'd1);
    run_cycle(1'b0, 4'hF, 4'h0);

    // Partial enable, then a disabled level that keeps requesting.
    do_reset();
    run_cycle(1'b0, 4'h5, 4'hF);
    check_eq("part_resume", 32'(resume), 32'h5);
    for (int k = 0; k < 6; k++) run_cycle(1'b0, 4'h5, 4'h2);
    check_eq("part_cnt1", 32'(pending[2*CB-1:CB]), 32'd0);

    // All levels disabled: no release.
    rc_snap = release_count;
    for (int k = 0; k < 20; k++) run_cycle(1'b0, 4'h0, 4'($urandom_range(0, 15)));
    check_eq("dis_rc", 32'(release_count), 32'(rc_snap));

    // Continuous valid: back-to-back releases and release-counter wrap.
    do_reset();
    for (int k = 0; k < 300; k++) run_cycle(1'b0, 4'hF, 4'hF);
    check_eq("wrap_rc", 32'(release_count), 32'd43);
    run_cycle(1'b1, 4'hF, 4'hF);
    check_eq("midrst_resume",  32'(resume), 32'd0);
    check_eq("midrst_pending", 32'(pending), 32'd0);

    // Long gather, then a late release.
    do_reset();
    run_cycle(1'b0, 4'hF, 4'h1);
    for (int k = 0; k < TMO + 4; k++) run_cycle(1'b0, 4'hF, 4'h0);
    run_cycle(1'b0, 4'hF, 4'hE);
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 4'hF, 4'h0);

    // Randomized traffic with occasional enable changes.
    do_reset();
    en = 4'hF;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        en = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      end
      if ($urandom_range(0, 199) == 0) run_cycle(1'b1, en, 4'($urandom_range(0, 15)));
      else                             run_cycle(1'b0, en, 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
